// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU and its command sequencer:
// op codes, ALU selector encodings and the sequencer FSM states.
package alu_pkg;

  // Command op codes as carried on cmd_op.
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_XOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MULT = 3'd6,
    OP_CLR  = 3'd7
  } op_t;

  // ALU in_selector encodings: bit2 persist, bit1 load, bit0 reset.
  typedef enum logic [2:0] {
    SEL_RESET   = 3'b001,
    SEL_LOAD    = 3'b010,
    SEL_PERSIST = 3'b100
  } in_sel_t;

  // ALU out_selector one-hot encodings.
  typedef enum logic [6:0] {
    OSEL_MULT = 7'b0000001,
    OSEL_SUB  = 7'b0000010,
    OSEL_ADD  = 7'b0000100,
    OSEL_XOR  = 7'b0001000,
    OSEL_NOT  = 7'b0010000,
    OSEL_OR   = 7'b0100000,
    OSEL_AND  = 7'b1000000
  } out_sel_t;

  // Sequencer FSM states (3-bit, separate from the ALU's own state codes).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } sq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response bus between a command source and the ALU op sequencer.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. The sender holds valid and its
// payload stable until that edge; ready may depend on state but never on
// valid. err_clr is a level sampled on the clock edge.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_load;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       err_clr;

  // Command source side.
  modport master (
    output cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b, rsp_ready, err_clr,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_load, cmd_a, cmd_b, rsp_ready, err_clr,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_op_decode.sv
// Maps a command op code onto the ALU out_selector one-hot and in_selector.
// CLR resets the ALU instead of loading operands.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [6:0] out_sel_o,
  output logic [2:0] in_sel_o
);

  // Combinational op decode; defaults first so no latch is inferred.
  always_comb begin
    out_sel_o = OSEL_ADD;
    in_sel_o  = SEL_LOAD;
    case (op_i)
      OP_AND:  out_sel_o = OSEL_AND;
      OP_OR:   out_sel_o = OSEL_OR;
      OP_NOT:  out_sel_o = OSEL_NOT;
      OP_XOR:  out_sel_o = OSEL_XOR;
      OP_ADD:  out_sel_o = OSEL_ADD;
      OP_SUB:  out_sel_o = OSEL_SUB;
      OP_MULT: out_sel_o = OSEL_MULT;
      OP_CLR: begin
        out_sel_o = OSEL_ADD;
        in_sel_o  = SEL_RESET;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side master for the 8-bit accumulator ALU. Accepts one command at
// a time, drives registered ALU operands/selectors, samples the result
// RESULT_LAT cycles after the ALU captures its operands and returns it over
// the response channel. Keeps a chaining accumulator and the overflow state.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int RESULT_LAT = 1,    // 1..7
  parameter bit OVF_STICKY = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [7:0]          alu_num1,
  output logic [7:0]          alu_num2,
  output logic [2:0]          alu_in_selector,
  output logic [6:0]          alu_out_selector,
  input  logic [7:0]          alu_result,
  input  logic                alu_overflow,
  output logic [2:0]          sq_state
);

  localparam logic [2:0] LAT_LAST = 3'(RESULT_LAT - 1);

  sq_state_t  state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic       err_q, err_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] num1_q, num1_d;
  logic [7:0] num2_q, num2_d;
  logic [2:0] in_sel_q, in_sel_d;
  logic [6:0] out_sel_q, out_sel_d;

  logic [6:0] dec_out_sel;
  logic [2:0] dec_in_sel;
  logic       cmd_accept;
  logic       smp_ovf;

  alu_op_decode u_decode (
    .op_i      (bus.cmd_op),
    .out_sel_o (dec_out_sel),
    .in_sel_o  (dec_in_sel)
  );

  // Ready only in IDLE, never during reset, and not while a sticky error is held.
  assign bus.cmd_ready = rst && (state_q == S_IDLE) && !(err_q && OVF_STICKY);
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;
  assign smp_ovf       = alu_overflow && (op_q == OP_MULT);

  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  assign alu_num1         = num1_q;
  assign alu_num2         = num2_q;
  assign alu_in_selector  = in_sel_q;
  assign alu_out_selector = out_sel_q;
  assign sq_state         = state_q;

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    in_sel_d   = in_sel_q;
    out_sel_d  = out_sel_q;
    case (state_q)
      S_IDLE: begin
        // ALU inputs are registered on the accept edge so they are live
        // during ISSUE and captured by the ALU at the end of it.
        if (cmd_accept) begin
          op_d      = bus.cmd_op;
          num1_d    = bus.cmd_load ? bus.cmd_a : acc_q;
          num2_d    = bus.cmd_b;
          in_sel_d  = dec_in_sel;
          out_sel_d = dec_out_sel;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rsp_err_d  = smp_ovf;
          rsp_data_d = (op_q == OP_CLR) ? 8'h00 : alu_result;
          if (op_q == OP_CLR) begin
            acc_d = 8'h00;
          end else if (!smp_ovf) begin
            acc_d = alu_result;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        // An err_clr arriving with the handshake cancels the sticky error.
        if (bus.rsp_ready) begin
          if (rsp_err_q && OVF_STICKY && !bus.err_clr) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (bus.err_clr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      num1_q     <= '0;
      num2_q     <= '0;
      in_sel_q   <= SEL_RESET;
      out_sel_q  <= OSEL_ADD;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      in_sel_q   <= in_sel_d;
      out_sel_q  <= out_sel_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a simple registered ALU stand-in, a table of
// fixed vectors, hand-written corner sequences and a randomized phase scored
// against an arithmetic reference model.
module tb_alu_op_sequencer;

  localparam logic [2:0] C_AND = 3'd0, C_OR = 3'd1, C_NOT = 3'd2, C_XOR = 3'd3,
                         C_ADD = 3'd4, C_SUB = 3'd5, C_MULT = 3'd6, C_CLR = 3'd7;

  logic       clk;
  logic       rst;
  logic [7:0] alu_num1, alu_num2, alu_result;
  logic [2:0] alu_in_selector, sq_state;
  logic [6:0] alu_out_selector;
  logic       alu_overflow;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.RESULT_LAT(1), .OVF_STICKY(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .alu_num1         (alu_num1),
    .alu_num2         (alu_num2),
    .alu_in_selector  (alu_in_selector),
    .alu_out_selector (alu_out_selector),
    .alu_result       (alu_result),
    .alu_overflow     (alu_overflow),
    .sq_state         (sq_state)
  );

  // Clock / reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: operand stage registered, result combinational from it.
  logic [7:0]  r1, r2;
  logic [6:0]  rsel;
  logic [15:0] prod;
  always @(posedge clk) begin
    if (alu_in_selector[0]) begin
      r1 <= 8'h00; r2 <= 8'h00; rsel <= 7'b0000100;
    end else if (alu_in_selector[1]) begin
      r1 <= alu_num1; r2 <= alu_num2; rsel <= alu_out_selector;
    end
  end
  always_comb begin
    prod         = {8'h00, r1} * {8'h00, r2};
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    case (rsel)
      7'b1000000: alu_result = r1 & r2;
      7'b0100000: alu_result = r1 | r2;
      7'b0010000: alu_result = ~r1;
      7'b0001000: alu_result = r1 ^ r2;
      7'b0000100: alu_result = r1 + r2;
      7'b0000010: alu_result = r1 - r2;
      7'b0000001: begin
        alu_result   = prod[7:0];
        alu_overflow = (prod > 16'd255);
      end
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: result and overflow of one op on plain integers.
  function automatic logic [8:0] ref_op(input logic [2:0] op, input int a, input int b);
    int r;
    bit e;
    e = 0;
    case (op)
      C_AND:  r = a & b;
      C_OR:   r = a | b;
      C_NOT:  r = 255 - a;
      C_XOR:  r = a ^ b;
      C_ADD:  r = (a + b) % 256;
      C_SUB:  r = (a - b + 256) % 256;
      C_MULT: begin r = (a * b) % 256; e = (a * b) > 255; end
      default: r = 0;
    endcase
    return {e, 8'(r)};
  endfunction

  // Driver: one full command/response transaction, starting and ending at a negedge.
  task automatic run_cmd(input logic [2:0] op, input logic load, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input logic [7:0] hold_exp,
                         input bit clr_at_rsp, output logic [7:0] data, output logic err,
                         output logic [2:0] issue_in_sel, output logic [7:0] issue_num1,
                         output int lat);
    int waitc;
    data = '0; err = 1'b0; issue_in_sel = '0; issue_num1 = '0; lat = 0;
    waitc = 0;
    while (bus.cmd_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) begin
      check("cmd_accept_timeout", 0, 1);
      return;
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_load = load;
    bus.cmd_a = a; bus.cmd_b = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    issue_in_sel = alu_in_selector;
    issue_num1 = alu_num1;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    data = bus.rsp_data;
    err = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_data", bus.rsp_data, hold_exp);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    bus.err_clr = clr_at_rsp;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.err_clr = 1'b0;
    check("rsp_single_cycle", bus.rsp_valid, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic       load;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0] d, n1;
    logic       e;
    logic [2:0] isel;
    int         lat;
    logic [7:0] acc_m;
    logic [8:0] exp;

    vecs[0] = '{C_AND,  1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{C_OR,   1'b0, 8'h00, 8'h0F, 8'h3F, 1'b0};
    vecs[2] = '{C_XOR,  1'b0, 8'h00, 8'hFF, 8'hC0, 1'b0};
    vecs[3] = '{C_NOT,  1'b0, 8'h00, 8'h00, 8'h3F, 1'b0};
    vecs[4] = '{C_ADD,  1'b0, 8'h00, 8'hC5, 8'h04, 1'b0};
    vecs[5] = '{C_SUB,  1'b0, 8'h00, 8'h05, 8'hFF, 1'b0};
    vecs[6] = '{C_MULT, 1'b1, 8'h0F, 8'h11, 8'hFF, 1'b0};
    vecs[7] = '{C_MULT, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[8] = '{C_CLR,  1'b1, 8'hAA, 8'hBB, 8'h00, 1'b0};
    vecs[9] = '{C_SUB,  1'b0, 8'h00, 8'h01, 8'hFF, 1'b0};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_load = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.rsp_ready = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_state", sq_state, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_num1", alu_num1, 0);
    check("rst_num2", alu_num2, 0);
    check("rst_in_sel", alu_in_selector, 3'b001);
    check("rst_out_sel", alu_out_selector, 7'b0000100);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_state", sq_state, 0);

    // Table-driven vectors (accumulator starts at 0).
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].load, vecs[i].a, vecs[i].b, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Basic ADD with load.
    run_cmd(C_ADD, 1'b1, 8'h12, 8'h34, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("add_data", d, 8'h46);
    check("add_err", e, 0);
    check("add_lat", lat, 3);
    check("add_issue_in_sel", isel, 3'b010);
    check("add_out_sel", alu_out_selector, 7'b0000100);

    // Chain ADD then SUB from the accumulator.
    run_cmd(C_ADD, 1'b1, 8'hF0, 8'h20, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("chain_add_data", d, 8'h10);
    run_cmd(C_SUB, 1'b0, 8'h00, 8'h11, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("chain_sub_data", d, 8'hFF);
    check("chain_sub_num1", n1, 8'h10);
    check("chain_sub_out_sel", alu_out_selector, 7'b0000010);

    // MULT overflow into sticky error.
    run_cmd(C_MULT, 1'b1, 8'h20, 8'h10, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("mult_ovf_err", e, 1);
    check("mult_ovf_data", d, 8'h00);
    for (int i = 0; i < 5; i++) begin
      check("err_cmd_ready", bus.cmd_ready, 0);
      check("err_state", sq_state, 4);
      @(negedge clk);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_clr_state", sq_state, 0);
    check("err_clr_cmd_ready", bus.cmd_ready, 1);
    run_cmd(C_ADD, 1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("acc_kept_after_ovf", d, 8'hFF);

    // Overflow with err_clr on the response handshake: straight back to IDLE.
    run_cmd(C_MULT, 1'b1, 8'hFF, 8'hFF, 0, 8'h00, 1'b1, d, e, isel, n1, lat);
    check("ovf_clr_err", e, 1);
    check("ovf_clr_data", d, 8'h01);
    check("ovf_clr_state", sq_state, 0);
    check("ovf_clr_cmd_ready", bus.cmd_ready, 1);

    // Backpressure: response held while rsp_ready is low.
    run_cmd(C_NOT, 1'b1, 8'h0F, 8'h00, 4, 8'hF0, 1'b0, d, e, isel, n1, lat);
    check("not_data", d, 8'hF0);

    // CLR after a result, then chain from the cleared accumulator.
    run_cmd(C_ADD, 1'b1, 8'h55, 8'h00, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("pre_clr_data", d, 8'h55);
    run_cmd(C_CLR, 1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("clr_issue_in_sel", isel, 3'b001);
    check("clr_data", d, 8'h00);
    run_cmd(C_ADD, 1'b0, 8'h00, 8'h07, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("post_clr_add", d, 8'h07);

    // Reset asserted during WAIT aborts the command.
    bus.cmd_valid = 1'b1; bus.cmd_op = C_ADD; bus.cmd_load = 1'b1;
    bus.cmd_a = 8'h09; bus.cmd_b = 8'h09;
    check("midrst_ready_before", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("midrst_issue_state", sq_state, 1);
    @(negedge clk);
    check("midrst_wait_state", sq_state, 2);
    rst = 1'b0;
    #1;
    check("midrst_state", sq_state, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_num1", alu_num1, 0);
    check("midrst_in_sel", alu_in_selector, 3'b001);
    check("midrst_out_sel", alu_out_selector, 7'b0000100);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", bus.rsp_valid, 0);
    end
    run_cmd(C_ADD, 1'b0, 8'h00, 8'h05, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
    check("midrst_next_cmd", d, 8'h05);

    // Randomized commands scored against the reference model.
    acc_m = 8'h05;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic       ld;
      logic [7:0] ra, rb, opa;
      op  = 3'($urandom_range(0, 7));
      ld  = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      opa = ld ? ra : acc_m;
      exp = (op == C_CLR) ? 9'h000 : ref_op(op, int'(opa), int'(rb));
      exp_q.push_back(exp);
      if (op == C_CLR) acc_m = 8'h00;
      else if (!exp[8]) acc_m = exp[7:0];
      run_cmd(op, ld, ra, rb, 0, 8'h00, 1'b0, d, e, isel, n1, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_data", i), d, exp[7:0]);
      check($sformatf("rand%0d_err", i), e, exp[8]);
      if (exp[8]) begin
        check($sformatf("rand%0d_err_ready", i), bus.cmd_ready, 0);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check($sformatf("rand%0d_stray_clr", i), bus.cmd_ready, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side master for the 8-bit accumulator ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand, in_selector and out_selector inputs.
- It samples the ALU result after the ALU's registered operand stage and returns it over a valid/ready response handshake.
- It keeps its own 8-bit accumulator so commands can chain. It also owns the overflow error state; the ALU only reports overflow combinationally.

Parameters:
- RESULT_LAT, 1, cycles from ALU operand capture edge to result sampling (legal range 1..7).
- OVF_STICKY, 1, 1 = overflow blocks new commands until err_clr; 0 = report the error on rsp_err only.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLR
- cmd_load  input  1  1 = operand A is cmd_a; 0 = operand A is internal accumulator
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  8  result byte
- rsp_err  output  1  result produced with overflow
- err_clr  input  1  clears sticky error
- alu_num1  output  8  to ALU num1
- alu_num2  output  8  to ALU num2
- alu_in_selector  output  3  to ALU in_selector; bit2 persist, bit1 load, bit0 reset
- alu_out_selector  output  7  to ALU out_selector, one-hot; bit6 AND, bit5 OR, bit4 NOT, bit3 XOR, bit2 ADD, bit1 SUB, bit0 MULT
- alu_result  input  8  from ALU outputVal
- alu_overflow  input  1  from ALU multiplier overflow
- sq_state  output  3  current FSM state (debug)

Behaviour:
- Reset is asynchronous, active-low (rst=0). While in reset and on the first cycle after reset:
  - state IDLE, cmd_ready=0 during reset; cmd_ready=1 in IDLE afterwards.
  - rsp_valid=0, rsp_data=0, rsp_err=0, acc_q=0, err_q=0.
  - alu_num1=alu_num2=0, alu_in_selector=3'b001, alu_out_selector=7'b0000100 (ADD).
- All ALU-facing outputs are registered. The persist selector is never driven, so chaining uses acc_q.
- States:
  - IDLE(0): cmd_ready=1 unless err_q && OVF_STICKY. On cmd_valid&&cmd_ready, latch the command and go to ISSUE.
  - ISSUE(1): for one cycle drive:
    - alu_num1 = cmd_load ? cmd_a : acc_q
    - alu_num2 = cmd_b
    - alu_in_selector = 3'b010
    - alu_out_selector = one-hot of cmd_op
    - For CLR, drive alu_in_selector=3'b001 instead.
    - Go to WAIT.
  - WAIT(2): hold all ALU outputs unchanged. The counter runs RESULT_LAT cycles. On its last cycle, sample alu_result and alu_overflow at the clock edge and go to RESP.
  - RESP(3): rsp_valid=1; rsp_data and rsp_err held stable until rsp_valid&&rsp_ready, then go to IDLE.
  - ERR(4): entered from RESP on handshake when rsp_err && OVF_STICKY. cmd_ready=0. err_clr=1 clears err_q and goes to IDLE next cycle.
- Latency: handshake at edge E0, ISSUE during cycle 1, result sampled at edge E(1+RESULT_LAT), rsp_valid high from the following cycle. With RESULT_LAT=1, rsp_valid rises 3 cycles after acceptance; back-to-back throughput is one command per 4 cycles.
- Arithmetic: all results are 8-bit and wrap. ADD drops carry; SUB is modulo 256. NOT uses operand A only.
- rsp_err = alu_overflow sampled && op==MULT; other ops force rsp_err=0.
- acc_q update: loaded with the sampled result when rsp_err=0. On overflow, acc_q is unchanged. CLR sets acc_q=0 and rsp_data=0.
- Boundaries:
  - cmd_valid while busy is ignored; the master holds it.
  - rsp_ready held high gives single-cycle rsp_valid.
  - err_clr outside ERR has no effect.
  - Simultaneous rsp handshake and err_clr in RESP: go to IDLE, err_q cleared.
  - Reset mid-WAIT: abort, no response emitted.
  - cmd_op is 3 bits, so all values are legal.

Decomposition:
- Shared package alu_pkg holds:
  - op codes OP_AND..OP_CLR;
  - in_selector constants SEL_PERSIST=3'b100, SEL_LOAD=3'b010, SEL_RESET=3'b001;
  - out_selector one-hot constants;
  - FSM state constants S_IDLE..S_ERR (3-bit, distinct from the ALU's 2-bit state constants).
- One natural sub-module: alu_op_decode (combinational cmd_op -> alu_out_selector/in_selector).

Test Plan:
- Reset, then cmd op=ADD, load=1, a=8'h12, b=8'h34 -> rsp_valid 3 cycles after accept, rsp_data=8'h46, rsp_err=0, alu_in_selector=010 in ISSUE.
- Chain: ADD load=1 a=8'hF0 b=8'h20 -> 8'h10; then SUB load=0 b=8'h11 -> rsp_data=8'hFF, alu_num1=8'h10.
- MULT a=8'h20 b=8'h10 with the ALU model asserting overflow -> rsp_err=1. Then ERR state, cmd_ready=0 for 5 cycles. err_clr pulse -> IDLE, cmd_ready=1, acc_q unchanged.
- Hold rsp_ready=0 for 4 cycles after NOT a=8'h0F -> rsp_valid and rsp_data=8'hF0 stable throughout; cmd_ready=0 until handshake.
- CLR after a prior result 8'h55 -> alu_in_selector=001 in ISSUE, rsp_data=0; next chained ADD b=8'h07 -> 8'h07.
- Assert rst=0 during WAIT -> all outputs return to reset values immediately, no rsp_valid afterwards; next command completes normally.
